aurora_pop_chk: RTL and testbench

Receive-side counterpart of the Aurora buffer-clear / end-of-packet pop generator. Sits on the user AXI-Stream output of the Aurora receive core, ahead of the downstream data FIFO. Classifies every accepted beat as payload, clear marker or pop filler. Forwards payload with one register stage, drops marker beats, and raises event pulses and counters for the control/register block.

---
 rtl/aurora_mark_pkg.sv | 41 ++++
 rtl/cmip_app_cnt.sv | 27 ++
 rtl/aurora_pop_chk.sv | 207 ++++++++++++++++++++
 tb/tb_aurora_pop_chk.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_mark_pkg.sv
// Shared marker definitions for the Aurora buffer-clear / end-of-packet pop
// generator (TX) and checker (RX).
// Contents: marker words, counter max constants, checker state enum,
// beat class enum and a beat classification helper.
package aurora_mark_pkg;

  // Marker words carried on the Aurora user stream
  localparam logic [127:0] CLR_WORD = 128'hAABBCCDD_AA55FF00_55AA0001_00000001;
  localparam logic [127:0] POP_WORD = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;

  // Counter maximum values
  localparam logic [7:0]  CNT8M  = 8'hFF;
  localparam logic [15:0] CNT16M = 16'hFFFF;
  localparam logic [31:0] CNT32M = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    CLR_RUN = 2'd1,
    POP_RUN = 2'd2
  } mark_state_e;

  typedef enum logic [1:0] {
    BEAT_DATA = 2'd0,
    BEAT_CLR  = 2'd1,
    BEAT_POP  = 2'd2
  } beat_cls_e;

  // A clear marker only counts when it closes a frame; pop filler ignores tlast.
  function automatic beat_cls_e classify_beat(input logic [127:0] data, input logic last);
    beat_cls_e cls;
    if ((data == CLR_WORD) && last) begin
      cls = BEAT_CLR;
    end else if (data == POP_WORD) begin
      cls = BEAT_POP;
    end else begin
      cls = BEAT_DATA;
    end
    return cls;
  endfunction

endpackage

// File: rtl/cmip_app_cnt.sv
// Generic event counter: increments by one on inc_i, wraps at 2^WIDTH.
// Ports: clk, rst_n (synchronous, active-low), inc_i (event), cnt_o (count).
module cmip_app_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Event count register, free-running wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else if (inc_i) begin
      cnt_q <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/aurora_pop_chk.sv
// Aurora RX marker checker. Classifies each accepted beat as payload, clear
// marker or pop filler; forwards payload through one register stage, drops
// marker beats, and reports buffer-clear / pop-end events with counters.
// Ports: clk, rst_n (sync, active-low); s_axis_* Aurora RX stream in;
// m_axis_* registered payload out; buff_clr / pop_end event pulses;
// pop_active level; buff_clr_cnt, last_pkt_cnt, pop_beat_cnt, short_clr_cnt.
module aurora_pop_chk
  import aurora_mark_pkg::*;
#(
  parameter int          DATA_WD = 128,
  parameter int          CLR_MIN = 20,
  parameter logic [23:0] POP_MAX = 24'd2097152,
  parameter logic [15:0] IDLE_TO = 16'd4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_WD-1:0]   s_axis_tdata,
  input  logic [DATA_WD/8-1:0] s_axis_tkeep,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [DATA_WD-1:0]   m_axis_tdata,
  output logic [DATA_WD/8-1:0] m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 buff_clr,
  output logic                 pop_end,
  output logic                 pop_active,
  output logic [31:0]          buff_clr_cnt,
  output logic [31:0]          last_pkt_cnt,
  output logic [31:0]          pop_beat_cnt,
  output logic [31:0]          short_clr_cnt
);

  localparam logic [23:0] CLR_LAST  = 24'(CLR_MIN - 1);
  localparam logic [23:0] POP_LAST  = POP_MAX - 24'd1;
  localparam logic [15:0] IDLE_LAST = IDLE_TO - 16'd1;

  mark_state_e          state_q, state_d;
  logic [23:0]          run_cnt_q, run_cnt_d;
  logic [15:0]          to_cnt_q, to_cnt_d;
  logic                 buff_clr_q, buff_clr_d;
  logic                 pop_end_q, pop_end_d;
  logic                 pop_active_q;
  logic                 m_valid_q;
  logic [DATA_WD-1:0]   m_data_q;
  logic [DATA_WD/8-1:0] m_keep_q;
  logic                 m_last_q;

  logic      accept_s;
  logic      fwd_s;
  logic      fresh_s;
  logic      short_inc_s;
  beat_cls_e cls_s;

  assign s_axis_tready = ~m_valid_q | m_axis_tready;
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign cls_s         = classify_beat(s_axis_tdata, s_axis_tlast);

  // Next-state, run/timeout counting and event decisions
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    to_cnt_d    = to_cnt_q;
    buff_clr_d  = 1'b0;
    pop_end_d   = 1'b0;
    short_inc_s = 1'b0;
    fresh_s     = 1'b0;
    fwd_s       = 1'b0;
    case (state_q)
      PASS: begin
        fresh_s = accept_s;
      end
      CLR_RUN: begin
        if (accept_s && (cls_s == BEAT_CLR)) begin
          if (run_cnt_q == CLR_LAST) begin
            buff_clr_d = 1'b1;
            state_d    = PASS;
            run_cnt_d  = 24'd0;
          end else begin
            run_cnt_d = run_cnt_q + 24'd1;
          end
        end else if (accept_s) begin
          // Any other beat aborts the clear sequence and is then treated fresh
          short_inc_s = 1'b1;
          fresh_s     = 1'b1;
        end else begin
          state_d = CLR_RUN;
        end
      end
      POP_RUN: begin
        if (accept_s && (cls_s == BEAT_POP)) begin
          to_cnt_d = 16'd0;
          if (run_cnt_q == POP_LAST) begin
            pop_end_d = 1'b1;
            state_d   = PASS;
            run_cnt_d = 24'd0;
          end else begin
            run_cnt_d = run_cnt_q + 24'd1;
          end
        end else if (accept_s) begin
          // A non-filler beat ends the run; the beat itself is handled fresh
          pop_end_d = 1'b1;
          to_cnt_d  = 16'd0;
          fresh_s   = 1'b1;
        end else if (to_cnt_q == IDLE_LAST) begin
          pop_end_d = 1'b1;
          state_d   = PASS;
          run_cnt_d = 24'd0;
          to_cnt_d  = 16'd0;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = PASS;
        run_cnt_d = 24'd0;
        to_cnt_d  = 16'd0;
      end
    endcase

    if (fresh_s) begin
      case (cls_s)
        BEAT_CLR: begin
          state_d   = CLR_RUN;
          run_cnt_d = 24'd1;
        end
        BEAT_POP: begin
          state_d   = POP_RUN;
          run_cnt_d = 24'd1;
          to_cnt_d  = 16'd0;
        end
        default: begin
          fwd_s     = 1'b1;
          state_d   = PASS;
          run_cnt_d = 24'd0;
        end
      endcase
    end else begin
      fwd_s = 1'b0;
    end
  end

  // Control state, run/timeout counters and event pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PASS;
      run_cnt_q    <= 24'd0;
      to_cnt_q     <= 16'd0;
      buff_clr_q   <= 1'b0;
      pop_end_q    <= 1'b0;
      pop_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      to_cnt_q     <= to_cnt_d;
      buff_clr_q   <= buff_clr_d;
      pop_end_q    <= pop_end_d;
      pop_active_q <= (state_d == POP_RUN);
    end
  end

  // Payload output register; holds while stalled downstream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= {DATA_WD{1'b0}};
      m_keep_q  <= {(DATA_WD/8){1'b0}};
      m_last_q  <= 1'b0;
    end else if (fwd_s) begin
      m_valid_q <= 1'b1;
      m_data_q  <= s_axis_tdata;
      m_keep_q  <= s_axis_tkeep;
      m_last_q  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_valid_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_q;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign buff_clr      = buff_clr_q;
  assign pop_end       = pop_end_q;
  assign pop_active    = pop_active_q;

  cmip_app_cnt #(.WIDTH(32)) u_buff_clr_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(buff_clr_d), .cnt_o(buff_clr_cnt)
  );

  cmip_app_cnt #(.WIDTH(32)) u_last_pkt_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(pop_end_d), .cnt_o(last_pkt_cnt)
  );

  cmip_app_cnt #(.WIDTH(32)) u_pop_beat_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(accept_s && (cls_s == BEAT_POP)), .cnt_o(pop_beat_cnt)
  );

  cmip_app_cnt #(.WIDTH(32)) u_short_clr_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(short_inc_s), .cnt_o(short_clr_cnt)
  );

endmodule

// File: tb/tb_aurora_pop_chk.sv
module tb_aurora_pop_chk;

  localparam int          CLR_MIN = 20;
  localparam logic [23:0] POP_MAX = 24'd128;
  localparam logic [15:0] IDLE_TO = 16'd200;
  localparam logic [127:0] CLRW = 128'hAABBCCDD_AA55FF00_55AA0001_00000001;
  localparam logic [127:0] POPW = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [127:0] s_tdata = '0;
  logic [15:0]  s_tkeep = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic         m_tready = 1'b1;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tlast, m_axis_tvalid;
  logic         buff_clr, pop_end, pop_active;
  logic [31:0]  buff_clr_cnt, last_pkt_cnt, pop_beat_cnt, short_clr_cnt;

  aurora_pop_chk #(.DATA_WD(128), .CLR_MIN(CLR_MIN), .POP_MAX(POP_MAX), .IDLE_TO(IDLE_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_tready),
    .buff_clr(buff_clr), .pop_end(pop_end), .pop_active(pop_active),
    .buff_clr_cnt(buff_clr_cnt), .last_pkt_cnt(last_pkt_cnt),
    .pop_beat_cnt(pop_beat_cnt), .short_clr_cnt(short_clr_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the stream means, tracked per accepted beat.
  // mode 0 = passing, 1 = inside a clear sequence, 2 = inside a pop run.
  int          mode = 0, run_n = 0, idle_n = 0;
  bit          e_bclr = 0, e_pend = 0, e_active = 0, m_occ = 0;
  int unsigned c_bclr = 0, c_last = 0, c_popb = 0, c_short = 0;
  logic [144:0] pq[$];

  function automatic int cls(input logic [127:0] d, input logic l);
    if (d == CLRW && l) return 1;
    if (d == POPW) return 2;
    return 0;
  endfunction

  task automatic drive(input bit v, input logic [127:0] d, input bit l, input bit mr);
    s_tvalid = v; s_tdata = d; s_tlast = l; s_tkeep = 16'($urandom); m_tready = mr;
  endtask

  // Advance one clock, updating the reference model with what happens at the edge.
  task automatic tick();
    bit acc, fresh;
    int c;
    acc = s_tvalid && (!m_occ || m_tready);
    c = cls(s_tdata, s_tlast);
    fresh = 0; e_bclr = 0; e_pend = 0;
    if (!rst_n) begin
      mode = 0; run_n = 0; idle_n = 0; m_occ = 0; pq.delete();
      c_bclr = 0; c_last = 0; c_popb = 0; c_short = 0;
    end else begin
      if (acc) begin
        if (c == 2) c_popb++;
        if (mode == 2) begin
          idle_n = 0;
          if (c == 2) begin
            run_n++;
            if (run_n == int'(POP_MAX)) begin e_pend = 1; mode = 0; end
          end else begin e_pend = 1; mode = 0; fresh = 1; end
        end else if (mode == 1) begin
          if (c == 1) begin
            run_n++;
            if (run_n == CLR_MIN) begin e_bclr = 1; mode = 0; end
          end else begin c_short++; mode = 0; fresh = 1; end
        end else fresh = 1;
        if (fresh) begin
          if (c == 1) begin mode = 1; run_n = 1; end
          else if (c == 2) begin mode = 2; run_n = 1; idle_n = 0; end
          else pq.push_back({s_tlast, s_tkeep, s_tdata});
        end
      end else if (mode == 2) begin
        idle_n++;
        if (idle_n == int'(IDLE_TO)) begin e_pend = 1; mode = 0; end
      end
      m_occ = (acc && fresh && c == 0) || (m_occ && !m_tready);
      if (e_bclr) c_bclr++;
      if (e_pend) c_last++;
    end
    e_active = rst_n && (mode == 2);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, '0, 0, 1);
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, POPW, 0, 0);
    tick(); tick();
    drive(0, '0, 0, 0);
    #1;
    n_vec++;
    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid, buff_clr, pop_end, pop_active} !== '0) begin
      n_err++; $display("FAIL reset_outputs got tvalid=%b tdata=%h pop_active=%b exp all zero", m_axis_tvalid, m_axis_tdata, pop_active);
    end
    n_vec++;
    if ({buff_clr_cnt, last_pkt_cnt, pop_beat_cnt, short_clr_cnt} !== 128'd0) begin
      n_err++; $display("FAIL reset_counters got %0d %0d %0d %0d exp 0 0 0 0", buff_clr_cnt, last_pkt_cnt, pop_beat_cnt, short_clr_cnt);
    end
    n_vec++;
    if (s_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready got %b exp 1", s_tready); end
    rst_n = 1'b1;
  endtask

  task automatic test_clr_run();
    do_reset();
    for (int i = 0; i < CLR_MIN; i++) begin
      drive(1, CLRW, 1, 1);
      tick();
      n_vec++;
      if (buff_clr !== 1'(i == CLR_MIN - 1)) begin n_err++; $display("FAIL clr_run buff_clr beat %0d got %b exp %b", i, buff_clr, i == CLR_MIN - 1); end
      n_vec++;
      if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL clr_run tvalid beat %0d got %b exp 0", i, m_axis_tvalid); end
    end
    drive(0, '0, 0, 1);
    tick();
    n_vec++;
    if (buff_clr !== 1'b0) begin n_err++; $display("FAIL clr_run pulse_width got %b exp 0", buff_clr); end
    n_vec++;
    if (buff_clr_cnt !== 32'd1) begin n_err++; $display("FAIL clr_run buff_clr_cnt got %0d exp 1", buff_clr_cnt); end
  endtask

  task automatic test_short_clr();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1, CLRW, 1, 1); tick(); end
    drive(1, 128'h1234, 1, 1);
    tick();
    n_vec++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 128'h1234) begin
      n_err++; $display("FAIL short_clr payload got v=%b d=%h exp v=1 d=1234", m_axis_tvalid, m_axis_tdata);
    end
    n_vec++;
    if (short_clr_cnt !== 32'd1) begin n_err++; $display("FAIL short_clr count got %0d exp 1", short_clr_cnt); end
    drive(0, '0, 0, 1);
    tick();
    n_vec++;
    if (buff_clr_cnt !== 32'd0 || m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL short_clr after got buff_clr_cnt=%0d tvalid=%b exp 0 0", buff_clr_cnt, m_axis_tvalid);
    end
  endtask

  task automatic test_pop_max();
    do_reset();
    for (int i = 0; i < int'(POP_MAX); i++) begin
      drive(1, POPW, $urandom_range(0, 1), 1);
      tick();
      n_vec++;
      if (pop_end !== 1'(i == int'(POP_MAX) - 1) || pop_active !== 1'(i != int'(POP_MAX) - 1)) begin
        n_err++; $display("FAIL pop_max beat %0d got pop_end=%b active=%b", i, pop_end, pop_active);
      end
    end
    drive(0, '0, 0, 1);
    tick();
    n_vec++;
    if (last_pkt_cnt !== 32'd1 || pop_beat_cnt !== 32'(POP_MAX) || pop_active !== 1'b0 || pop_end !== 1'b0) begin
      n_err++; $display("FAIL pop_max end got last=%0d beats=%0d active=%b pop_end=%b exp 1 %0d 0 0", last_pkt_cnt, pop_beat_cnt, pop_active, pop_end, POP_MAX);
    end
  endtask

  task automatic test_pop_idle();
    do_reset();
    for (int i = 0; i < 100; i++) begin drive(1, POPW, 0, 1); tick(); end
    // An accept in the cycle the timeout would fire keeps the run alive
    drive(0, '0, 0, 1);
    for (int j = 1; j < int'(IDLE_TO); j++) tick();
    drive(1, POPW, 0, 1);
    tick();
    n_vec++;
    if (pop_end !== 1'b0 || pop_active !== 1'b1) begin
      n_err++; $display("FAIL pop_idle accept_wins got pop_end=%b active=%b exp 0 1", pop_end, pop_active);
    end
    drive(0, '0, 0, 1);
    for (int j = 1; j <= int'(IDLE_TO) + 2; j++) begin
      tick();
      n_vec++;
      if (pop_end !== 1'(j == int'(IDLE_TO)) || pop_active !== 1'(j < int'(IDLE_TO))) begin
        n_err++; $display("FAIL pop_idle idle cycle %0d got pop_end=%b active=%b", j, pop_end, pop_active);
      end
    end
    n_vec++;
    if (last_pkt_cnt !== 32'd1 || pop_beat_cnt !== 32'd101) begin
      n_err++; $display("FAIL pop_idle counts got last=%0d beats=%0d exp 1 101", last_pkt_cnt, pop_beat_cnt);
    end
  endtask

  task automatic test_pop_then_clr();
    do_reset();
    for (int i = 0; i < 50; i++) begin drive(1, POPW, 1, 1); tick(); end
    for (int i = 0; i < CLR_MIN; i++) begin
      drive(1, CLRW, 1, 1);
      tick();
      n_vec++;
      if (pop_end !== 1'(i == 0) || buff_clr !== 1'(i == CLR_MIN - 1)) begin
        n_err++; $display("FAIL pop_then_clr beat %0d got pop_end=%b buff_clr=%b", i, pop_end, buff_clr);
      end
    end
    n_vec++;
    if (last_pkt_cnt !== 32'd1 || buff_clr_cnt !== 32'd1 || pop_beat_cnt !== 32'd50 || short_clr_cnt !== 32'd0) begin
      n_err++; $display("FAIL pop_then_clr counts got %0d %0d %0d %0d exp 1 1 50 0", last_pkt_cnt, buff_clr_cnt, pop_beat_cnt, short_clr_cnt);
    end
  endtask

  task automatic test_random_backpressure();
    logic [144:0] exp_b;
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 15);
      if (r < 2)       drive($urandom_range(0, 3) != 0, CLRW, 1, $urandom_range(0, 2) != 0);
      else if (r == 2) drive($urandom_range(0, 3) != 0, CLRW, 0, $urandom_range(0, 2) != 0);
      else if (r < 5)  drive($urandom_range(0, 3) != 0, POPW, $urandom_range(0, 1), $urandom_range(0, 2) != 0);
      else drive($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1), $urandom_range(0, 2) != 0);
      #1;
      n_vec++;
      if (s_tready !== (!m_occ || m_tready)) begin n_err++; $display("FAIL rand tready cyc %0d got %b exp %b", i, s_tready, !m_occ || m_tready); end
      if (m_axis_tvalid && m_tready) begin
        n_vec++;
        if (pq.size() == 0) begin
          n_err++; $display("FAIL rand payload cyc %0d got extra beat %h exp none", i, m_axis_tdata);
        end else begin
          exp_b = pq.pop_front();
          if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== exp_b) begin
            n_err++; $display("FAIL rand payload cyc %0d got %h exp %h", i, {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_b);
          end
        end
      end
      tick();
      n_vec++;
      if (m_axis_tvalid !== m_occ || buff_clr !== e_bclr || pop_end !== e_pend || pop_active !== e_active) begin
        n_err++; $display("FAIL rand ctrl cyc %0d got v=%b clr=%b end=%b act=%b exp %b %b %b %b", i, m_axis_tvalid, buff_clr, pop_end, pop_active, m_occ, e_bclr, e_pend, e_active);
      end
      n_vec++;
      if (buff_clr_cnt !== c_bclr || last_pkt_cnt !== c_last || pop_beat_cnt !== c_popb || short_clr_cnt !== c_short) begin
        n_err++; $display("FAIL rand counters cyc %0d got %0d %0d %0d %0d exp %0d %0d %0d %0d", i, buff_clr_cnt, last_pkt_cnt, pop_beat_cnt, short_clr_cnt, c_bclr, c_last, c_popb, c_short);
      end
    end
    // Drain: the held beat must still come out
    drive(0, '0, 0, 1);
    if (m_axis_tvalid) begin
      n_vec++;
      exp_b = (pq.size() != 0) ? pq.pop_front() : 145'd0;
      if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== exp_b) begin
        n_err++; $display("FAIL rand drain got %h exp %h", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_b);
      end
    end
    tick();
    n_vec++;
    if (pq.size() != 0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rand loss got pending=%0d tvalid=%b exp 0 0", pq.size(), m_axis_tvalid); end
  endtask

  task automatic test_reset_mid_pop();
    do_reset();
    for (int i = 0; i < 10; i++) begin drive(1, POPW, 0, 1); tick(); end
    rst_n = 1'b0;
    drive(1, POPW, 0, 1);
    tick();
    n_vec++;
    if ({m_axis_tvalid, buff_clr, pop_end, pop_active, buff_clr_cnt, last_pkt_cnt, pop_beat_cnt, short_clr_cnt} !== '0) begin
      n_err++; $display("FAIL mid_reset outputs got active=%b pop_beats=%0d exp all zero", pop_active, pop_beat_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < int'(POP_MAX); i++) begin drive(1, POPW, 0, 1); tick(); end
    n_vec++;
    if (pop_end !== 1'b1 || last_pkt_cnt !== 32'd1 || pop_beat_cnt !== 32'(POP_MAX)) begin
      n_err++; $display("FAIL mid_reset rerun got pop_end=%b last=%0d beats=%0d exp 1 1 %0d", pop_end, last_pkt_cnt, pop_beat_cnt, POP_MAX);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clr_run();
    test_short_clr();
    test_pop_max();
    test_pop_idle();
    test_pop_then_clr();
    test_random_backpressure();
    test_reset_mid_pop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
